pad_pixel_streamer: RTL and testbench
=====================================

// Module: pad_pixel_streamer
// PURPOSE
//  Producer side of the 5x5 window line buffer: reads an NxN feature map (N=28/14/7) per channel
//  from activation memory and emits it raster-order with zero padding on all sides.
//  Drives the buffer's write interface: input_pixel, wr_en, window_done and end_of_layer.
//  One padded frame is sent per channel, then a one-cycle flush that clears the buffer.
// PARAMETERS
//  bitsize    14  pixel width, signed two's complement
//  maxfiforaw 28  largest supported N
//  padding    2   zero border width, P
//  ADDR_W     16  activation memory address width
//  CH_W       8   channel count width
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous reset, active low
//  start          in   1        1-cycle pulse; samples layer_fifosize, base_addr, num_ch
//  layer_fifosize in   6        N; legal values are 28, 14 and 7
//  base_addr      in   ADDR_W   address of pixel (ch0,0,0)
//  num_ch         in   CH_W     number of channels; 0 is treated as 1
//  hold           in   1        back-pressure; freezes the issue stage
//  mem_rd_en      out  1        memory read strobe; rdata is valid the next cycle
//  mem_addr       out  ADDR_W   memory read address
//  mem_rdata      in   bitsize  memory read data
//  input_pixel    out  bitsize  pixel to the line buffer
//  wr_en          out  1        pixel write strobe
//  window_done    out  1        buffer clear; coincides with the flush wr_en
//  end_of_layer   out  1        asserted with the flush of the last channel
//  busy           out  1        high whenever the FSM is not in IDLE
//  cfg_err        out  1        1-cycle pulse when start arrives with an illegal N
// BEHAVIOUR
//  Reset values:
//   - all outputs are 0; FSM = IDLE; all counters are 0.
//   - a reset asserted mid-frame aborts the frame immediately; no flush is emitted.
//  Geometry: W = N + 2P.
//  FSM states:
//   - IDLE:
//     - on start with a legal N, latch the configuration, set row=col=ch=0, go to STREAM.
//     - on start with an illegal N, pulse cfg_err and stay in IDLE.
//     - start is ignored while busy.
//   - STREAM: each non-hold cycle issues position (row,col).
//     - interior means P<=row<N+P and P<=col<N+P.
//     - for an interior position, mem_rd_en=1 and mem_addr=rd_ptr; rd_ptr then increments by 1.
//     - for a border position, mem_rd_en=0.
//     - col wraps at W-1 and row increments. At (W-1,W-1) go to FLUSH.
//   - FLUSH: one cycle; no read is issued.
//     - if ch==num_ch-1, go to IDLE; otherwise ch+1, row=col=0, back to STREAM.
//     - rd_ptr continues linearly, so channel c starts at base_addr + c*N*N.
//  Output stage: registered, latency 1 from issue.
//   - an issued position gives wr_en=1 on the next cycle.
//   - input_pixel = mem_rdata if interior, else 0.
//   - a FLUSH gives wr_en=1, input_pixel=0, window_done=1 on the next cycle.
//   - end_of_layer is also 1 on that cycle if the flush belongs to the last channel.
//  Hold:
//   - sampled at the issue stage only: no issue, and row/col/rd_ptr/state are frozen.
//   - the in-flight pixel still emerges, so wr_en falls one cycle after hold rises.
//   - hold during FLUSH delays the flush.
//  Counts and timing:
//   - exactly W*W pixel writes plus 1 flush per channel, with no gaps when hold=0.
//   - busy falls on the cycle after the last flush is issued.
//  Widths: mem_addr wraps modulo 2^ADDR_W; no overflow detection.
// CONFIGURATION
//  PAD_STREAM_PERF_EN defined:
//   - adds output perf_wr_cnt [31:0], which counts wr_en cycles including flushes.
//   - cleared on reset and on an accepted start; saturates at all ones.
//  PAD_STREAM_PERF_EN undefined: the port and the counter are absent.
// TESTING
//  - N=7, P=2, num_ch=1, base=0x100, hold=0 -> 121 wr_en then 1 flush with window_done=end_of_layer=1.
//    The first interior pixel is write #24, read from 0x100; the last read is 0x130.
//  - N=14, num_ch=3 -> 324 writes + flush per channel; end_of_layer only on the 3rd flush.
//    Channel 2 starts at base+392.
//  - Zero border check: mem_rdata forced to 0x1FFF -> every border pixel is 0x0000.
//    Every interior pixel is 0x1FFF.
//  - hold high for 5 cycles mid-row (N=28) -> wr_en low for 5 cycles starting 1 cycle later.
//    No pixel is lost or duplicated; the address sequence stays contiguous.
//  - start with layer_fifosize=10 -> cfg_err 1-cycle pulse, busy stays 0.
//    start arriving while busy -> ignored.
//  - rst low mid-frame -> the next cycle has all outputs 0 and state IDLE.
//    A fresh start then replays the frame from base_addr.

Source files
------------

// File: rtl/pad_pixel_streamer.sv
// pad_pixel_streamer
//   Producer side of the 5x5 window line buffer. For each channel it reads an
//   NxN feature map (N = 28/14/7) from activation memory and emits it in raster
//   order, surrounded by a zero border `padding` pixels wide. A one-cycle flush
//   (window_done) follows each channel. end_of_layer marks the flush of the
//   last channel.
//
// Ports
//   clk, rst             clock; synchronous active-low reset
//   start                1-cycle pulse; samples layer_fifosize, base_addr, num_ch
//   layer_fifosize[5:0]  N (legal: 28, 14, 7)
//   base_addr            address of pixel (ch0,0,0)
//   num_ch               channel count (0 is treated as 1)
//   hold                 back-pressure; freezes the issue stage
//   mem_rd_en/mem_addr   memory read request; mem_rdata is valid one cycle later
//   mem_rdata            memory read data
//   input_pixel, wr_en   pixel write to the line buffer (1-cycle latency from issue)
//   window_done          buffer clear; coincides with the flush write
//   end_of_layer         set with the flush of the last channel
//   busy                 FSM not idle
//   cfg_err              1-cycle pulse on start with an illegal N
//   perf_wr_cnt[31:0]    saturating wr_en count (only with PAD_STREAM_PERF_EN)
//
// Build option: define PAD_STREAM_PERF_EN to add perf_wr_cnt.
module pad_pixel_streamer #(
    parameter int bitsize    = 14,
    parameter int maxfiforaw = 28,
    parameter int padding    = 2,
    parameter int ADDR_W     = 16,
    parameter int CH_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [5:0]         layer_fifosize,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [CH_W-1:0]    num_ch,
    input  logic               hold,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [bitsize-1:0] mem_rdata,
    output logic [bitsize-1:0] input_pixel,
    output logic               wr_en,
    output logic               window_done,
    output logic               end_of_layer,
    output logic               busy,
    output logic               cfg_err
`ifdef PAD_STREAM_PERF_EN
    ,
    output logic [31:0]        perf_wr_cnt
`endif
);

    localparam int CW = (maxfiforaw + 2*padding + 1 > 64) ? $clog2(maxfiforaw + 2*padding + 1) : 6;
    localparam logic [CW-1:0] PAD = CW'(padding);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     row_q, row_d, col_q, col_d;
    logic [CW-1:0]     n_q, n_d;
    logic [CH_W-1:0]   ch_q, ch_d, ch_last_q, ch_last_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic              interior, last_pos_edge_col, last_row;
    logic              issue, flush_go, start_bad;
    logic              wr_en_q, int_q, wd_q, eol_q, cfg_err_q;

    assign interior = (row_q >= PAD) && (row_q < n_q + PAD) &&
                      (col_q >= PAD) && (col_q < n_q + PAD);
    assign last_pos_edge_col = (col_q == n_q + PAD + PAD - CW'(1));
    assign last_row          = (row_q == n_q + PAD + PAD - CW'(1));

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        ch_d      = ch_q;
        rd_ptr_d  = rd_ptr_q;
        n_d       = n_q;
        ch_last_d = ch_last_q;
        issue     = 1'b0;
        flush_go  = 1'b0;
        start_bad = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (layer_fifosize == 6'd28 || layer_fifosize == 6'd14 || layer_fifosize == 6'd7) begin
                        n_d       = CW'(layer_fifosize);
                        ch_last_d = (num_ch == '0) ? '0 : num_ch - CH_W'(1);
                        rd_ptr_d  = base_addr;
                        row_d     = '0;
                        col_d     = '0;
                        ch_d      = '0;
                        state_d   = STREAM;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (!hold) begin
                    issue = 1'b1;
                    if (interior) begin
                        mem_rd_en = 1'b1;
                        mem_addr  = rd_ptr_q;
                        rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
                    end
                    if (last_pos_edge_col) begin
                        col_d = '0;
                        if (last_row) begin
                            row_d   = '0;
                            state_d = FLUSH;
                        end else begin
                            row_d = row_q + CW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            FLUSH: begin
                if (!hold) begin
                    flush_go = 1'b1;
                    if (ch_q == ch_last_q) begin
                        state_d = IDLE;
                    end else begin
                        ch_d    = ch_q + CH_W'(1);
                        row_d   = '0;
                        col_d   = '0;
                        state_d = STREAM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            n_q       <= '0;
            ch_q      <= '0;
            ch_last_q <= '0;
            rd_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            int_q     <= 1'b0;
            wd_q      <= 1'b0;
            eol_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            n_q       <= n_d;
            ch_q      <= ch_d;
            ch_last_q <= ch_last_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_en_q   <= issue | flush_go;
            int_q     <= issue & interior;
            wd_q      <= flush_go;
            eol_q     <= flush_go & (ch_q == ch_last_q);
            cfg_err_q <= start_bad;
        end
    end

    // Read data arrives one cycle after the request, i.e. in the same cycle as
    // the registered write strobe, so the pixel mux uses the live mem_rdata.
    assign input_pixel  = int_q ? mem_rdata : '0;
    assign wr_en        = wr_en_q;
    assign window_done  = wd_q;
    assign end_of_layer = eol_q;
    assign busy         = (state_q != IDLE);
    assign cfg_err      = cfg_err_q;

`ifdef PAD_STREAM_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_wr_cnt <= '0;
        end else if (start && state_q == IDLE && state_d == STREAM) begin
            perf_wr_cnt <= '0;
        end else if (wr_en_q && perf_wr_cnt != '1) begin
            perf_wr_cnt <= perf_wr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pad_pixel_streamer.sv
module tb_pad_pixel_streamer;

    logic        clk, rst, start, hold;
    logic [5:0]  layer_fifosize;
    logic [15:0] base_addr;
    logic [7:0]  num_ch;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [13:0] mem_rdata;
    logic [13:0] input_pixel;
    logic        wr_en, window_done, end_of_layer, busy, cfg_err;
`ifdef PAD_STREAM_PERF_EN
    logic [31:0] perf_wr_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit ones_mode = 1'b0;

    pad_pixel_streamer #(
        .bitsize(14), .maxfiforaw(28), .padding(2), .ADDR_W(16), .CH_W(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .layer_fifosize(layer_fifosize),
        .base_addr(base_addr), .num_ch(num_ch), .hold(hold),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .input_pixel(input_pixel), .wr_en(wr_en), .window_done(window_done),
        .end_of_layer(end_of_layer), .busy(busy), .cfg_err(cfg_err)
`ifdef PAD_STREAM_PERF_EN
        , .perf_wr_cnt(perf_wr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Activation memory: each word holds its own address, or 0x1FFF in ones mode.
    initial mem_rdata = '0;
    always @(posedge clk)
        if (mem_rd_en) mem_rdata <= ones_mode ? 14'h1FFF : mem_addr[13:0];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_addr"}, 32'(mem_addr), 32'h0);
        check_val({tag, "_flags"},
                  32'({mem_rd_en, wr_en, window_done, end_of_layer, busy, cfg_err, input_pixel}), 32'h0);
    endtask

    // {window_done, end_of_layer, pixel} expected for write number idx (0-based).
    function automatic logic [15:0] exp_word(input int idx, input int n, input int nch,
                                             input logic [15:0] base);
        int w, fr, ch, p, r, c;
        logic [15:0] a;
        w  = n + 4;
        fr = w * w + 1;
        ch = idx / fr;
        p  = idx % fr;
        if (p == w * w) return {1'b1, (ch == nch - 1), 14'h0};
        r = p / w;
        c = p % w;
        if (r >= 2 && r < n + 2 && c >= 2 && c < n + 2) begin
            if (ones_mode) return 16'h1FFF;
            a = base + 16'(ch * n * n + (r - 2) * n + (c - 2));
            return {2'b00, a[13:0]};
        end
        return 16'h0;
    endfunction

    task automatic stream(input int n, input int nch_in, input logic [15:0] base,
                          input int hold_at, input int hold_len, input int busy_start_at);
        int nch, total, idx, cyc, gaps, first_gap, rd_cnt, limit;
        logic [15:0] exp_rd;
        nch = (nch_in == 0) ? 1 : nch_in;
        total = nch * ((n + 4) * (n + 4) + 1);
        idx = 0; cyc = 0; gaps = 0; first_gap = -1; rd_cnt = 0;
        exp_rd = base;
        limit = total + hold_len + 20;
        @(negedge clk);
        layer_fifosize = 6'(n); base_addr = base; num_ch = 8'(nch_in); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("busy_after_start", 32'(busy), 32'h1);
        while (idx < total && cyc < limit) begin
            hold = (hold_len > 0 && cyc >= hold_at && cyc < hold_at + hold_len);
            if (cyc == busy_start_at) begin
                start = 1'b1; layer_fifosize = 6'd7; base_addr = 16'hABC0; num_ch = 8'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (mem_rd_en) begin
                check_val("rd_addr", 32'(mem_addr), 32'(exp_rd));
                exp_rd++;
                rd_cnt++;
            end
            if (wr_en) begin
                check_val("pixel", 32'({window_done, end_of_layer, input_pixel}),
                          32'(exp_word(idx, n, nch, base)));
                idx++;
            end else begin
                gaps++;
                if (first_gap < 0) first_gap = cyc;
            end
        end
        hold = 1'b0;
        start = 1'b0;
        check_val("writes", 32'(idx), 32'(total));
        check_val("reads", 32'(rd_cnt), 32'(nch * n * n));
        check_val("gaps", 32'(gaps), 32'(hold_len));
        if (hold_len > 0) check_val("gap_start", 32'(first_gap), 32'(hold_at + 1));
        check_val("busy_end", 32'(busy), 32'h0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; hold = 1'b0;
        layer_fifosize = '0; base_addr = '0; num_ch = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b1;

        // Illegal N: cfg_err pulses once, FSM stays idle.
        @(negedge clk);
        layer_fifosize = 6'd10; num_ch = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("cfg_err_pulse", 32'(cfg_err), 32'h1);
        check_val("cfg_err_busy", 32'(busy), 32'h0);
        @(negedge clk);
        check_val("cfg_err_clear", 32'(cfg_err), 32'h0);
        check_val("cfg_err_busy2", 32'(busy), 32'h0);

        stream(7, 1, 16'h0100, 0, 0, -1);
`ifdef PAD_STREAM_PERF_EN
        check_val("perf_cnt", perf_wr_cnt, 32'd122);
`endif
        stream(14, 3, 16'h0040, 0, 0, 50);       // includes a start while busy
        ones_mode = 1'b1;
        stream(7, 0, 16'h0300, 0, 0, -1);        // num_ch=0 behaves as 1
        ones_mode = 1'b0;
        stream(28, 1, 16'h0400, 70, 5, -1);      // 5-cycle hold mid-row

        // Reset mid-frame, then replay from base.
        @(negedge clk);
        layer_fifosize = 6'd7; base_addr = 16'h0100; num_ch = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("midframe_rst");
        rst = 1'b1;
        stream(7, 1, 16'h0100, 0, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
